// File: rtl/minirv_pkg.sv
// Shared encodings, FSM state type and byte-lane helper for the multi-cycle miniRV core.
package minirv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  function automatic logic [31:0] load_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'h00_0000, b};
  endfunction

endpackage

// File: rtl/minirv_rf.sv
// Register file: two async read ports, one write port, x0 reads as zero.
module minirv_rf
  import minirv_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NREGS)-1:0]   raddr1_i,
  input  logic [$clog2(NREGS)-1:0]   raddr2_i,
  output logic [31:0]                rdata1_o,
  output logic [31:0]                rdata2_o,
  input  logic                       we_i,
  input  logic [$clog2(NREGS)-1:0]   waddr_i,
  input  logic [31:0]                wdata_i,
  output logic [NREGS-1:0][31:0]     regs_o
);

  logic [NREGS-1:0][31:0] regs_q;

  // Writes to x0 are dropped so entry 0 keeps its reset value of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
  assign regs_o   = regs_q;

endmodule

// File: rtl/minirv_mc.sv
// Multi-cycle RV32 subset core sharing one valid/ready memory port for fetch and data.
module minirv_mc
  import minirv_pkg::*;
#(
  parameter int          NREGS    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  output logic [31:0]            pc,
  output logic [NREGS-1:0][31:0] regs_out,
  output logic                   retire,
  output logic                   ebreak,
  output logic                   illegal
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  state_t      state_q;
  logic [31:0] pc_q, ir_q, ea_q;
  logic        ebreak_q, illegal_q;

  logic [6:0]  opcode_s, funct7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s;
  logic [31:0] rs1_val_s, rs2_val_s, pc_plus4_s, br_target_s, ea_s;

  assign opcode_s = ir_q[6:0];
  assign rd_s     = ir_q[11:7];
  assign funct3_s = ir_q[14:12];
  assign rs1_s    = ir_q[19:15];
  assign rs2_s    = ir_q[24:20];
  assign funct7_s = ir_q[31:25];

  assign imm_i_s  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_st_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b_s  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u_s  = {ir_q[31:12], 12'h000};

  assign pc_plus4_s  = pc_q + 32'd4;
  assign br_target_s = pc_q + imm_b_s;
  assign ea_s        = rs1_val_s + ((opcode_s == STORE) ? imm_st_s : imm_i_s);

  logic legal_s, use_rd_s, use_rs1_s, use_rs2_s, range_bad_s;

  // Legal encodings and which register fields each one actually reads or writes.
  always_comb begin
    legal_s   = 1'b0;
    use_rd_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    case (opcode_s)
      OP_IMM: begin legal_s = (funct3_s == 3'b000); use_rd_s = 1'b1; use_rs1_s = 1'b1; end
      OP: begin
        legal_s  = (funct3_s == 3'b000) && (funct7_s == 7'b0000000);
        use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      LUI:    begin legal_s = 1'b1; use_rd_s = 1'b1; end
      JALR:   begin legal_s = (funct3_s == 3'b000); use_rd_s = 1'b1; use_rs1_s = 1'b1; end
      BRANCH: begin
        legal_s   = (funct3_s == F3_BEQ) || (funct3_s == F3_BNE);
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      LOAD:   begin
        legal_s  = (funct3_s == F3_LW) || (funct3_s == F3_LBU);
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
      end
      STORE:  begin
        legal_s   = (funct3_s == F3_SW) || (funct3_s == F3_SB);
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      SYSTEM:  legal_s = (ir_q == EBREAK_INSN);
      default: legal_s = 1'b0;
    endcase
  end

  assign range_bad_s = (use_rd_s  && ({1'b0, rd_s}  >= NREGS_W)) ||
                       (use_rs1_s && ({1'b0, rs1_s} >= NREGS_W)) ||
                       (use_rs2_s && ({1'b0, rs2_s} >= NREGS_W));

  logic        ex_trap_s, ex_wb_s, ex_mem_s, ex_brk_s;
  logic [31:0] ex_wdata_s, ex_pc_s;

  // Execute-cycle outcome; a trap suppresses every architectural update.
  always_comb begin
    ex_trap_s  = 1'b0;
    ex_wb_s    = 1'b0;
    ex_mem_s   = 1'b0;
    ex_brk_s   = 1'b0;
    ex_wdata_s = rs1_val_s + imm_i_s;
    ex_pc_s    = pc_plus4_s;
    if (!legal_s || range_bad_s) begin
      ex_trap_s = 1'b1;
    end else begin
      case (opcode_s)
        OP_IMM: ex_wb_s = 1'b1;
        OP:     begin ex_wb_s = 1'b1; ex_wdata_s = rs1_val_s + rs2_val_s; end
        LUI:    begin ex_wb_s = 1'b1; ex_wdata_s = imm_u_s; end
        JALR: begin
          ex_wb_s    = 1'b1;
          ex_wdata_s = pc_plus4_s;
          ex_pc_s    = (rs1_val_s + imm_i_s) & ~32'd3;
        end
        BRANCH: begin
          if ((rs1_val_s == rs2_val_s) == (funct3_s == F3_BEQ)) begin
            ex_pc_s   = br_target_s;
            ex_trap_s = (br_target_s[1:0] != 2'b00);
          end else begin
            ex_pc_s   = pc_plus4_s;
          end
        end
        LOAD, STORE: begin
          // LW and SW share funct3, so one test covers word alignment for both.
          if ((funct3_s == F3_LW) && (ea_s[1:0] != 2'b00)) begin
            ex_trap_s = 1'b1;
          end else begin
            ex_mem_s  = 1'b1;
          end
        end
        SYSTEM:  ex_brk_s  = 1'b1;
        default: ex_trap_s = 1'b1;
      endcase
    end
  end

  // Control FSM with the architectural pc, instruction and effective-address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      ea_q      <= 32'h0000_0000;
      ebreak_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (ex_trap_s) begin
            illegal_q <= 1'b1;
            state_q   <= HALT;
          end else if (ex_brk_s) begin
            ebreak_q  <= 1'b1;
            state_q   <= HALT;
          end else if (ex_mem_s) begin
            ea_q      <= ea_s;
            state_q   <= MEM;
          end else begin
            pc_q      <= ex_pc_s;
            state_q   <= FETCH;
          end
        end
        MEM: begin
          if (mem_ready) begin
            pc_q    <= pc_plus4_s;
            state_q <= FETCH;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  // Gating with reset_n drops an in-flight request the moment reset asserts.
  assign mem_req = reset_n && ((state_q == FETCH) || (state_q == MEM));

  // Memory port payload, held constant by the FSM while a request stalls.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_wstrb = 4'b0000;
    if (mem_req && (state_q == MEM)) begin
      mem_addr = {ea_q[31:2], 2'b00};
      if (opcode_s == STORE) begin
        mem_we = 1'b1;
        if (funct3_s == F3_SW) begin
          mem_wstrb = 4'b1111;
          mem_wdata = rs2_val_s;
        end else begin
          mem_wstrb = 4'b0001 << ea_q[1:0];
          mem_wdata = {4{rs2_val_s[7:0]}};
        end
      end else begin
        mem_we = 1'b0;
      end
    end else if (mem_req) begin
      mem_addr = pc_q;
    end else begin
      mem_addr = 32'h0000_0000;
    end
  end

  logic        rf_we_s;
  logic [31:0] rf_wdata_s;

  // Register write-back from the execute cycle or from a completed load.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_wdata_s = ex_wdata_s;
    if (state_q == EXEC) begin
      rf_we_s = ex_wb_s && !ex_trap_s;
    end else if ((state_q == MEM) && mem_ready && (opcode_s == LOAD)) begin
      rf_we_s    = 1'b1;
      rf_wdata_s = (funct3_s == F3_LW) ? mem_rdata : load_byte(mem_rdata, ea_q[1:0]);
    end else begin
      rf_we_s = 1'b0;
    end
  end

  minirv_rf #(.NREGS(NREGS)) u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .raddr1_i (rs1_s[AW-1:0]),
    .raddr2_i (rs2_s[AW-1:0]),
    .rdata1_o (rs1_val_s),
    .rdata2_o (rs2_val_s),
    .we_i     (rf_we_s),
    .waddr_i  (rd_s[AW-1:0]),
    .wdata_i  (rf_wdata_s),
    .regs_o   (regs_out)
  );

  assign retire  = ((state_q == EXEC) && !ex_trap_s && !ex_mem_s) ||
                   ((state_q == MEM) && mem_ready);
  assign pc      = pc_q;
  assign ebreak  = ebreak_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_minirv_mc.sv
// Scoreboard bench: expected retire pcs and store beats are queued per program and popped as the core produces them.
module tb_minirv_mc;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mem_req, mem_we, mem_ready;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]        mem_wstrb;
  logic [15:0][31:0] regs_out;
  logic              retire, ebreak, illegal;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;

  logic [31:0] mem [256];
  logic [31:0] prog [$];
  logic [31:0] exp_pc_q [$];
  wr_t         wr_q [$];
  logic [31:0] exp_regs [16];
  int          ready_mode = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          retired_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);

  minirv_mc #(.NREGS(16), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .regs_out(regs_out), .retire(retire), .ebreak(ebreak), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Ready pattern advances just after each rising edge so it is stable around both edges.
  initial forever begin
    @(posedge clk);
    #1 cyc++;
  end

  // Memory model and store scoreboard: a handshake visible at the falling edge completes at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (reset_n && mem_req && mem_ready) begin
      xfer_cnt++;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        if (wr_q.size() > 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_wdata, w.data);
          check("wr_strb", {28'h0, mem_wstrb}, {28'h0, w.strb});
        end else begin
          check("wr_unexpected", {31'h0, mem_we}, 32'h0);
        end
      end
    end
  end

  // Retire scoreboard.
  initial forever begin
    @(negedge clk);
    if (retire) begin
      retired_cnt++;
      if (exp_pc_q.size() > 0) check("retire_pc", pc, exp_pc_q.pop_front());
      else check("retire_unexpected", {31'h0, retire}, 32'h0);
    end
  end

  // Request payload must not move while a request is stalled.
  initial begin
    logic        pend;
    logic [31:0] s_addr, s_data;
    logic [4:0]  s_ctl;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && reset_n && mem_req) begin
        check("stall_addr", mem_addr, s_addr);
        check("stall_wdata", mem_wdata, s_data);
        check("stall_we_strb", {27'h0, mem_we, mem_wstrb}, {27'h0, s_ctl});
      end
      pend   = reset_n && mem_req && !mem_ready;
      s_addr = mem_addr;
      s_data = mem_wdata;
      s_ctl  = {mem_we, mem_wstrb};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input int mode, input int pre_idx, input logic [31:0] pre_val);
    reset_n = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    foreach (prog[i]) mem[i] = prog[i];
    mem[pre_idx] = pre_val;
    ready_mode = mode;
    xfer_cnt = 0;
    retired_cnt = 0;
    exp_pc_q.delete();
    wr_q.delete();
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_x%0d", tag, i), regs_out[i], exp_regs[i]);
  endtask

  task automatic finish_prog(input string tag, input logic [31:0] epc, input logic eb, input logic il);
    int n;
    n = 0;
    while (n < 400 && !(ebreak || illegal)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'h0, ebreak | illegal}, 32'h1);
    repeat (5) tick();
    check({tag, "_pc"}, pc, epc);
    check({tag, "_ebreak"}, {31'h0, ebreak}, {31'h0, eb});
    check({tag, "_illegal"}, {31'h0, illegal}, {31'h0, il});
    check({tag, "_halt_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_retires_left"}, exp_pc_q.size(), 32'h0);
    check({tag, "_writes_left"}, wr_q.size(), 32'h0);
    check_regs(tag);
  endtask

  task automatic load_basic();
    prog = '{enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI),
             enc_i(32'hFFFF_FFF9, 5'd1, 3'b000, 5'd2, OPI),
             enc_r(5'd2, 5'd1, 5'd3),
             EBRK};
  endtask

  task automatic expect_basic();
    exp_pc_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_regs[1] = 32'h5;
    exp_regs[2] = 32'hFFFF_FFFE;
    exp_regs[3] = 32'h3;
  endtask

  initial begin
    int n;
    wr_t w;

    load_basic();
    start(0, 255, 32'h0);
    check("reset_regs_x1", regs_out[1], 32'h0);
    expect_basic();
    finish_prog("alu0", 32'hC, 1'b1, 1'b0);
    check("alu0_retired", retired_cnt, 32'd4);

    load_basic();
    start(1, 255, 32'h0);
    expect_basic();
    finish_prog("alu3", 32'hC, 1'b1, 1'b0);
    check("alu3_retired", retired_cnt, 32'd4);

    prog = '{enc_i(32'h0AB, 5'd0, 3'b000, 5'd1, OPI),
             enc_s(32'h103, 5'd1, 5'd0, 3'b000),
             enc_i(32'h103, 5'd0, 3'b100, 5'd4, OPL),
             enc_i(32'h100, 5'd0, 3'b010, 5'd5, OPL),
             EBRK};
    start(1, 32'h40, 32'h1122_3344);
    exp_pc_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    w.addr = 32'h100; w.data = 32'hABAB_ABAB; w.strb = 4'b1000;
    wr_q.push_back(w);
    exp_regs[1] = 32'hAB;
    exp_regs[4] = 32'hAB;
    exp_regs[5] = 32'hAB22_3344;
    finish_prog("sbl", 32'h10, 1'b1, 1'b0);

    prog = '{enc_i(32'd1, 5'd0, 3'b000, 5'd1, OPI),
             enc_b(32'd8, 5'd1, 5'd0, 3'b001),
             enc_i(32'd9, 5'd0, 3'b000, 5'd9, OPI),
             enc_b(32'd8, 5'd1, 5'd0, 3'b000),
             enc_i(32'h20, 5'd0, 3'b000, 5'd1, OPI),
             enc_i(32'd1, 5'd1, 3'b000, 5'd1, 7'b1100111),
             EBRK, EBRK, EBRK};
    start(0, 255, 32'h0);
    exp_pc_q = '{32'h0, 32'h4, 32'hC, 32'h10, 32'h14, 32'h20};
    exp_regs[1] = 32'h18;
    finish_prog("br", 32'h20, 1'b1, 1'b0);

    prog = '{enc_i(32'd3, 5'd0, 3'b000, 5'd1, OPI),
             enc_i(32'd1, 5'd0, 3'b000, 5'd17, OPI),
             EBRK};
    start(0, 255, 32'h0);
    exp_pc_q = '{32'h0};
    exp_regs[1] = 32'h3;
    finish_prog("rng", 32'h4, 1'b0, 1'b1);

    prog = '{enc_i(32'h100, 5'd0, 3'b000, 5'd1, OPI),
             enc_i(32'd2, 5'd1, 3'b010, 5'd2, OPL),
             EBRK};
    start(1, 32'h40, 32'hCAFE_F00D);
    exp_pc_q = '{32'h0};
    exp_regs[1] = 32'h100;
    finish_prog("mis", 32'h4, 1'b0, 1'b1);
    check("mis_xfers", xfer_cnt, 32'd2);

    prog = '{enc_i(32'd7, 5'd0, 3'b000, 5'd0, OPI),
             enc_b(32'd6, 5'd0, 5'd0, 3'b000),
             EBRK, EBRK};
    start(0, 255, 32'h0);
    exp_pc_q = '{32'h0};
    finish_prog("brmis", 32'h4, 1'b0, 1'b1);

    load_basic();
    start(1, 255, 32'h0);
    expect_basic();
    n = 0;
    while (n < 200 && !(mem_req && !mem_ready && retired_cnt >= 2)) begin
      @(negedge clk);
      n++;
    end
    check("rst_stall_seen", {31'h0, mem_req & ~mem_ready}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_req_async", {31'h0, mem_req}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_retire", {31'h0, retire}, 32'h0);
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    check_regs("rst");
    exp_pc_q.delete();
    repeat (2) tick();
    expect_basic();
    reset_n = 1'b1;
    n = 0;
    while (n < 20 && !mem_req) begin
      @(negedge clk);
      n++;
    end
    check("rst_refetch_addr", mem_addr, 32'h0);
    finish_prog("rst", 32'hC, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
